// File: rtl/smoosh_pkg.sv
// Shared game types: attack kinds, default player/hitbox dimensions and the
// per-player snapshot record used by the combat arbiter.
package smoosh_pkg;

  typedef enum logic [2:0] {
    ATK_NONE = 3'd0,
    NEUTRAL  = 3'd1,
    ATK_UP   = 3'd2,
    ATK_DOWN = 3'd3,
    ATK_SIDE = 3'd4
  } attack_state;

  localparam int DEF_PLAYER_W = 32;
  localparam int DEF_PLAYER_H = 32;
  localparam int DEF_HB_W     = 24;
  localparam int DEF_HB_H     = 16;
  localparam int DEF_HB_YOFF  = 8;

  typedef enum logic [1:0] {IDLE, CHECK_P1, CHECK_P2, APPLY} res_state_e;

  typedef struct packed {
    logic        active;
    attack_state atk;
    logic        facing_left;
    logic [9:0]  x;
    logic [9:0]  y;
  } player_snap_t;

endpackage

// File: rtl/hitbox_check.sv
// Attacker hitbox vs victim hurtbox overlap test, half-open on both axes.
module hitbox_check #(
  parameter int PLAYER_W = 32,
  parameter int PLAYER_H = 32,
  parameter int HB_W     = 24,
  parameter int HB_H     = 16,
  parameter int HB_YOFF  = 8
) (
  input  logic [9:0] atk_x_i,
  input  logic [9:0] atk_y_i,
  input  logic       atk_facing_left_i,
  input  logic [9:0] vic_x_i,
  input  logic [9:0] vic_y_i,
  output logic       overlap_o
);

  // 11-bit so x+PLAYER_W+HB_W never wraps
  logic [10:0] ax, ay, vx, vy;
  logic [10:0] hb_xlo, hb_xhi, hb_ylo, hb_yhi;

  assign ax = {1'b0, atk_x_i};
  assign ay = {1'b0, atk_y_i};
  assign vx = {1'b0, vic_x_i};
  assign vy = {1'b0, vic_y_i};

  always_comb begin
    hb_xlo = ax + 11'(PLAYER_W);
    hb_xhi = ax + 11'(PLAYER_W + HB_W);
    if (atk_facing_left_i) begin
      hb_xlo = (ax < 11'(HB_W)) ? 11'd0 : ax - 11'(HB_W);
      hb_xhi = ax;
    end
  end

  assign hb_ylo = ay + 11'(HB_YOFF);
  assign hb_yhi = ay + 11'(HB_YOFF + HB_H);

  assign overlap_o = (hb_xlo < vx + 11'(PLAYER_W)) && (vx < hb_xhi) &&
                     (hb_ylo < vy + 11'(PLAYER_H)) && (vy < hb_yhi);

endmodule

// File: rtl/hit_resolver.sv
// Per-frame combat arbiter: snapshots both players on frame_tick, checks each
// attack in turn through one shared hitbox_check, then applies hits or a clash.
module hit_resolver
  import smoosh_pkg::*;
#(
  parameter int PLAYER_W    = DEF_PLAYER_W,
  parameter int PLAYER_H    = DEF_PLAYER_H,
  parameter int HB_W        = DEF_HB_W,
  parameter int HB_H        = DEF_HB_H,
  parameter int HB_YOFF     = DEF_HB_YOFF,
  parameter int NEUTRAL_DMG = 8,
  parameter int HITSTUN     = 20,
  parameter int DMG_MAX     = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        p1_attack_active,
  input  attack_state p1_atk_state,
  input  logic        p1_facing_left,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic        p2_attack_active,
  input  attack_state p2_atk_state,
  input  logic        p2_facing_left,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [9:0]  p1_damage,
  output logic [9:0]  p2_damage,
  output logic        p1_stunned,
  output logic        p2_stunned,
  output logic        p1_hit_pulse,
  output logic        p2_hit_pulse,
  output logic        clash_pulse,
  output logic        busy
);

  res_state_e   state_q;
  player_snap_t snap1_q, snap2_q, atk, vic;
  logic         landed1_q, landed2_q, hit1_q, hit2_q;
  logic         hp1_q, hp2_q, clash_q;
  logic [6:0]   stun1_q, stun2_q;
  logic [9:0]   dmg1_q, dmg2_q, dmg1_d, dmg2_d;
  logic         ok1, ok2, overlap;

  // CHECK_P1 tests P1 on P2; every other state presents P2 on P1
  assign atk = (state_q == CHECK_P1) ? snap1_q : snap2_q;
  assign vic = (state_q == CHECK_P1) ? snap2_q : snap1_q;

  hitbox_check #(
    .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H),
    .HB_W(HB_W), .HB_H(HB_H), .HB_YOFF(HB_YOFF)
  ) u_hb (
    .atk_x_i(atk.x), .atk_y_i(atk.y), .atk_facing_left_i(atk.facing_left),
    .vic_x_i(vic.x), .vic_y_i(vic.y), .overlap_o(overlap)
  );

  assign ok1 = snap1_q.active && (snap1_q.atk != ATK_NONE) && (stun1_q == 7'd0) && !landed1_q;
  assign ok2 = snap2_q.active && (snap2_q.atk != ATK_NONE) && (stun2_q == 7'd0) && !landed2_q;

  function automatic logic [9:0] sat_add(input logic [9:0] d);
    logic [10:0] s;
    s = {1'b0, d} + 11'(NEUTRAL_DMG);
    return (s > 11'(DMG_MAX)) ? 10'(DMG_MAX) : s[9:0];
  endfunction

  assign dmg1_d = sat_add(dmg1_q);
  assign dmg2_d = sat_add(dmg2_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      snap1_q   <= '0;
      snap2_q   <= '0;
      landed1_q <= 1'b0;
      landed2_q <= 1'b0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      stun1_q   <= '0;
      stun2_q   <= '0;
      dmg1_q    <= '0;
      dmg2_q    <= '0;
      hp1_q     <= 1'b0;
      hp2_q     <= 1'b0;
      clash_q   <= 1'b0;
    end else begin
      hp1_q   <= 1'b0;
      hp2_q   <= 1'b0;
      clash_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_tick) begin
          snap1_q <= '{p1_attack_active, p1_atk_state, p1_facing_left, p1_x, p1_y};
          snap2_q <= '{p2_attack_active, p2_atk_state, p2_facing_left, p2_x, p2_y};
          // decrement before the checks so a timer at 1 frees this frame
          stun1_q <= (stun1_q != 7'd0) ? stun1_q - 7'd1 : 7'd0;
          stun2_q <= (stun2_q != 7'd0) ? stun2_q - 7'd1 : 7'd0;
          state_q <= CHECK_P1;
        end
        CHECK_P1: begin
          hit1_q  <= ok1 && overlap;
          state_q <= CHECK_P2;
        end
        CHECK_P2: begin
          hit2_q  <= ok2 && overlap;
          state_q <= APPLY;
        end
        APPLY: begin
          state_q <= IDLE;
          if (!snap1_q.active) landed1_q <= 1'b0;
          if (!snap2_q.active) landed2_q <= 1'b0;
          if (hit1_q && hit2_q) begin
            clash_q   <= 1'b1;
            landed1_q <= 1'b1;
            landed2_q <= 1'b1;
          end else if (hit1_q) begin
            dmg2_q    <= dmg2_d;
            stun2_q   <= 7'(HITSTUN);
            hp2_q     <= 1'b1;
            landed1_q <= 1'b1;
          end else if (hit2_q) begin
            dmg1_q    <= dmg1_d;
            stun1_q   <= 7'(HITSTUN);
            hp1_q     <= 1'b1;
            landed2_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p1_damage    = dmg1_q;
  assign p2_damage    = dmg2_q;
  assign p1_stunned   = (stun1_q != 7'd0);
  assign p2_stunned   = (stun2_q != 7'd0);
  assign p1_hit_pulse = hp1_q;
  assign p2_hit_pulse = hp2_q;
  assign clash_pulse  = clash_q;
  assign busy         = (state_q != IDLE);

endmodule
